// File: rtl/fetch_if.sv
// fetch_if: groups the fetch stage's hazard/redirect controls, the instruction
// memory port and the IF/ID pipeline register outputs into one bundle.
//  master modport: the fetch stage (drives imem_addr and the IF/ID outputs)
//  slave modport : the surrounding pipeline (hazard unit, ID stage, imem)
//  stall, redirect, redirect_pc : hold / taken branch-jump controls into fetch
//  imem_addr, imem_data         : combinational-read instruction memory port
//  id_instr, id_pc, id_pc_plus4, id_valid : IF/ID pipeline register contents
//  halted, fetch_count          : halt status and delivered-instruction count
interface fetch_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc_plus4;
  logic             id_valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, halted, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS CPU. Owns the PC,
// presents it as the instruction-memory address, and loads the IF/ID register.
// Next PC is PC+4 or an ID-stage redirect; supports stall, flush and halt, and
// counts instructions delivered into IF/ID.
//  clk   : single clock, all state updates on the rising edge
//  reset : synchronous, active-high, overrides every other input
//  bus   : fetch_if master modport (controls, imem port, IF/ID outputs, status)
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          CNT_W      = 32
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e           state_q,       state_d;
  logic [31:0]      pc_q,          pc_d;
  logic [31:0]      id_instr_q,    id_instr_d;
  logic [31:0]      id_pc_q,       id_pc_d;
  logic [31:0]      id_pc_plus4_q, id_pc_plus4_d;
  logic             id_valid_q,    id_valid_d;
  logic             halted_q,      halted_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  // Next-state and IF/ID load selection; priority redirect > stall > halt > sequential.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_RUN: begin
        if (bus.redirect) begin
          // Flush the wrong-path word; the target is forced word-aligned.
          pc_d       = {bus.redirect_pc[31:2], 2'b00};
          id_valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.imem_data == HALT_INSTR) begin
          // The halt word itself never enters IF/ID; PC stays on it.
          state_d    = ST_HALTED;
          id_valid_d = 1'b0;
        end else begin
          id_instr_d    = bus.imem_data;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_q + 32'd4;
          id_valid_d    = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        id_valid_d = 1'b0;
      end
      default: begin
        // Unreachable encoding: park in HALTED with a bubble until reset.
        state_d    = ST_HALTED;
        id_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      id_instr_q    <= 32'h0000_0000;
      id_pc_q       <= 32'h0000_0000;
      id_pc_plus4_q <= 32'h0000_0000;
      id_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule
